// File: rtl/riscv_pkg.sv
// Shared rv32i pipeline types and constants used by the load/store stage.
package riscv_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned BE_W = XLEN / 8;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } instruction_t;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} memstage_state_e;

endpackage

// File: rtl/memstage_if.sv
// Data-memory req/gnt/rvalid port between the load/store stage and memory.
interface memstage_if;
  import riscv_pkg::*;

  logic            mem_req;
  logic            mem_we;
  logic [BE_W-1:0] mem_be;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic            mem_gnt;
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );

endinterface

// File: rtl/memstage_memalign.sv
// Combinational byte-lane logic: store enables/data, access legality, load extraction.
module memalign
  import riscv_pkg::*;
(
  input  logic            is_load,
  input  logic            is_store,
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] store_data,
  output logic [BE_W-1:0] be,
  output logic [XLEN-1:0] wdata,
  output logic            fault,
  input  logic [2:0]      ld_funct3,
  input  logic [1:0]      ld_addr_lo,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] ld_data
);

  logic            misaligned;
  logic            illegal;
  logic [XLEN-1:0] shifted;

  // Size comes from funct3[1:0]; size 3 never reaches memory because it is illegal.
  always_comb begin
    be         = '0;
    wdata      = store_data;
    misaligned = 1'b0;
    case (funct3[1:0])
      2'b00: begin
        be    = BE_W'(4'b0001 << addr_lo);
        wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        be         = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata      = {2{store_data[15:0]}};
        misaligned = addr_lo[0];
      end
      2'b10: begin
        be         = 4'b1111;
        misaligned = |addr_lo;
      end
      default: be = '0;
    endcase
  end

  always_comb begin
    illegal = 1'b0;
    if (is_load)
      illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
    else if (is_store)
      illegal = (funct3 > F3_W);
    fault = (is_load || is_store) && (illegal || misaligned);
  end

  assign shifted = rdata >> {ld_addr_lo, 3'b000};

  always_comb begin
    ld_data = rdata;
    case (ld_funct3)
      F3_B:    ld_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   ld_data = {24'd0, shifted[7:0]};
      F3_H:    ld_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   ld_data = {16'd0, shifted[15:0]};
      default: ld_data = rdata;
    endcase
  end

endmodule

// File: rtl/memstage.sv
// rv32i load/store stage: one outstanding data-memory access, valid/ready toward writeback.
module memstage
  import riscv_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  instruction_t    instruction_i,
  input  logic [XLEN-1:0] data_i,
  input  logic [XLEN-1:0] store_data_i,
  output logic            valid_o,
  input  logic            ready_i,
  output instruction_t    instruction_o,
  output logic [XLEN-1:0] data_o,
  output logic            fault_o,
  memstage_if.master      mem
);

  memstage_state_e state_q, state_d;

  logic            valid_q, valid_d;
  logic            fault_q, fault_d;
  logic [XLEN-1:0] data_q, data_d;
  instruction_t    instr_q, instr_d;
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic [BE_W-1:0] be_q, be_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [2:0]      ld_f3_q, ld_f3_d;
  logic [1:0]      ld_lo_q, ld_lo_d;

  logic            is_load_c, is_store_c, accept_c, fault_c;
  logic [BE_W-1:0] be_c;
  logic [XLEN-1:0] wdata_c, ld_data_c;

  assign is_load_c  = (instruction_i.opcode == OPC_LOAD);
  assign is_store_c = (instruction_i.opcode == OPC_STORE);
  assign ready_o    = (state_q == IDLE) && (!valid_q || ready_i);
  assign accept_c   = valid_i && ready_o;

  memalign u_memalign (
    .is_load    (is_load_c),
    .is_store   (is_store_c),
    .funct3     (instruction_i.funct3),
    .addr_lo    (data_i[1:0]),
    .store_data (store_data_i),
    .be         (be_c),
    .wdata      (wdata_c),
    .fault      (fault_c),
    .ld_funct3  (ld_f3_q),
    .ld_addr_lo (ld_lo_q),
    .rdata      (mem.mem_rdata),
    .ld_data    (ld_data_c)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and next values of every registered output.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    fault_d = fault_q;
    data_d  = data_q;
    instr_d = instr_q;
    req_d   = req_q;
    we_d    = we_q;
    be_d    = be_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ld_f3_d = ld_f3_q;
    ld_lo_d = ld_lo_q;

    if (valid_q && ready_i) valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept_c) begin
          data_d  = data_i;
          instr_d = instruction_i;
          if ((is_load_c || is_store_c) && !fault_c) begin
            req_d   = 1'b1;
            we_d    = is_store_c;
            be_d    = be_c;
            addr_d  = {data_i[XLEN-1:2], 2'b00};
            wdata_d = wdata_c;
            ld_f3_d = instruction_i.funct3;
            ld_lo_d = data_i[1:0];
            state_d = REQ;
          end else begin
            valid_d = 1'b1;
            fault_d = fault_c;
          end
        end
      end
      REQ: begin
        if (mem.mem_gnt) begin
          req_d = 1'b0;
          if (we_q) begin
            valid_d = 1'b1;
            fault_d = 1'b0;
            state_d = IDLE;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (mem.mem_rvalid) begin
          data_d  = ld_data_c;
          valid_d = 1'b1;
          fault_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      data_q  <= '0;
      instr_q <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      ld_f3_q <= '0;
      ld_lo_q <= '0;
    end else begin
      valid_q <= valid_d;
      fault_q <= fault_d;
      data_q  <= data_d;
      instr_q <= instr_d;
      req_q   <= req_d;
      we_q    <= we_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ld_f3_q <= ld_f3_d;
      ld_lo_q <= ld_lo_d;
    end
  end

  assign valid_o       = valid_q;
  assign fault_o       = fault_q;
  assign data_o        = data_q;
  assign instruction_o = instr_q;
  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_be    = be_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;

endmodule

// File: tb/tb_memstage.sv
// Bench for memstage: directed vector table, randomized ops against a reference model, reset abort.
module tb_memstage;
  import riscv_pkg::*;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         valid_i, ready_o, valid_o, ready_i, fault_o;
  instruction_t instruction_i, instruction_o;
  logic [31:0]  data_i, store_data_i, data_o;

  memstage_if mif();

  memstage dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .valid_i       (valid_i),
    .ready_o       (ready_o),
    .instruction_i (instruction_i),
    .data_i        (data_i),
    .store_data_i  (store_data_i),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .instruction_o (instruction_o),
    .data_o        (data_o),
    .fault_o       (fault_o),
    .mem           (mif)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit          mem;
    bit          we;
    logic [3:0]  be;
    logic [31:0] wdata;
    bit          fault;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    instruction_t ins;
    logic [31:0]  d, sd, rd;
    int           gd, rvd, rdyd;
    exp_t         e;
  } vec_t;

  int    n_vec = 0;
  int    n_err = 0;
  string cur_tag = "";

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s/%s: got %h expected %h", cur_tag, name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic instruction_t mki(input logic [6:0] opc, input logic [2:0] f3, input logic [4:0] rd);
    instruction_t i;
    i = instruction_t'(32'h0000_0000);
    i.opcode = opc;
    i.funct3 = f3;
    i.rd     = rd;
    i.rs1    = 5'd3;
    i.rs2    = 5'd9;
    return i;
  endfunction

  function automatic exp_t mke(input bit m, input bit w, input logic [3:0] be,
                               input logic [31:0] wd, input bit f, input logic [31:0] d);
    exp_t e;
    e.mem = m; e.we = w; e.be = be; e.wdata = wd; e.fault = f; e.data = d;
    return e;
  endfunction

  // Reference: size in bytes, alignment by modulo, lanes by byte arithmetic.
  function automatic exp_t model(input instruction_t ins, input logic [31:0] d, sd, rd);
    exp_t   e;
    bit     ld, st, legal;
    int     nb, off;
    longint v, span;
    ld = (ins.opcode == 7'b0000011);
    st = (ins.opcode == 7'b0100011);
    nb = 1 << ins.funct3[1:0];
    off = int'(d[1:0]);
    e = mke(0, st, 4'h0, 32'h0, 0, d);
    if (ld || st) begin
      legal = ld ? !(ins.funct3 inside {3'b011, 3'b110, 3'b111}) : (ins.funct3 <= 3'd2);
      if (!legal || (off % nb) != 0) begin
        e.fault = 1;
      end else begin
        e.mem = 1;
        e.be  = 4'(((1 << nb) - 1) << off);
        for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = sd[8*(i % nb) +: 8];
        if (ld) begin
          span = longint'(1) << (8 * nb);
          v = longint'(rd >> (8 * off)) % span;
          if (!ins.funct3[2] && nb < 4 && v >= span / 2) v = v - span;
          e.data = 32'(v);
        end
      end
    end
    return e;
  endfunction

  task automatic run_op(input string tag, input instruction_t ins, input logic [31:0] d, sd, rd,
                        input int gd, rvd, rdyd, input exp_t e);
    int cyc, rc, wc, lat_exp;
    bit granted, done, saw_req;
    cur_tag = tag;
    lat_exp = !e.mem ? 1 : (e.we ? 2 + gd : 3 + gd + rvd);
    instruction_i = ins; data_i = d; store_data_i = sd;
    valid_i = 1'b1; ready_i = 1'b1;
    #1;
    chk("ready_idle", 32'(ready_o), 32'd1);
    step();
    valid_i = 1'b0;
    data_i = $urandom; store_data_i = $urandom; instruction_i = instruction_t'($urandom);
    cyc = 0; rc = 0; wc = 0; granted = 0; done = 0; saw_req = 0;
    while (!done && cyc < 64) begin
      cyc++;
      mif.mem_gnt = 1'b0; mif.mem_rvalid = 1'b0; mif.mem_rdata = $urandom;
      if (valid_o) begin
        chk("latency", 32'(cyc), 32'(lat_exp));
        chk("req_seen", 32'(saw_req), 32'(e.mem));
        chk("req_off", 32'(mif.mem_req), 32'd0);
        chk("fault", 32'(fault_o), 32'(e.fault));
        chk("data", data_o, e.data);
        chk("instr", 32'(instruction_o), 32'(ins));
        for (int k = 0; k < rdyd; k++) begin
          ready_i = 1'b0;
          #1;
          chk("ready_stall", 32'(ready_o), 32'd0);
          step();
          chk("hold_valid", 32'(valid_o), 32'd1);
          chk("hold_data", data_o, e.data);
        end
        ready_i = 1'b1;
        step();
        chk("valid_clear", 32'(valid_o), 32'd0);
        done = 1;
      end else begin
        if (e.mem) chk("ready_busy", 32'(ready_o), 32'd0);
        if (mif.mem_req) begin
          saw_req = 1;
          chk("addr", mif.mem_addr, {d[31:2], 2'b00});
          chk("be", 32'(mif.mem_be), 32'(e.be));
          chk("we", 32'(mif.mem_we), 32'(e.we));
          if (e.we) chk("wdata", mif.mem_wdata, e.wdata);
          if (rc == gd) begin
            mif.mem_gnt = 1'b1;
            granted = 1;
          end else begin
            mif.mem_rvalid = 1'b1;
          end
          rc++;
        end else if (granted) begin
          if (wc == rvd) begin
            mif.mem_rvalid = 1'b1;
            mif.mem_rdata  = rd;
          end else begin
            mif.mem_gnt = 1'b1;
          end
          wc++;
        end
        step();
      end
    end
    mif.mem_gnt = 1'b0; mif.mem_rvalid = 1'b0;
    if (!done) begin
      n_vec++; n_err++;
      $display("FAIL %s/timeout: no valid_o within 64 cycles, required latency %0d", tag, lat_exp);
    end
  endtask

  task automatic chk_reset_state();
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_fault", 32'(fault_o), 32'd0);
    chk("rst_data", data_o, 32'd0);
    chk("rst_instr", 32'(instruction_o), 32'd0);
    chk("rst_req", 32'(mif.mem_req), 32'd0);
    chk("rst_we", 32'(mif.mem_we), 32'd0);
    chk("rst_be", 32'(mif.mem_be), 32'd0);
    chk("rst_addr", mif.mem_addr, 32'd0);
    chk("rst_wdata", mif.mem_wdata, 32'd0);
    chk("rst_ready", 32'(ready_o), 32'd1);
  endtask

  task automatic reset_mid(input string tag, input bit in_wait);
    cur_tag = tag;
    instruction_i = mki(7'b0000011, 3'b010, 5'd7);
    data_i = 32'h300; store_data_i = 32'h0; valid_i = 1'b1; ready_i = 1'b1;
    step();
    valid_i = 1'b0;
    chk("req_up", 32'(mif.mem_req), 32'd1);
    if (in_wait) begin
      mif.mem_gnt = 1'b1;
      step();
      mif.mem_gnt = 1'b0;
      chk("req_down", 32'(mif.mem_req), 32'd0);
    end
    rst_i = 1'b0;
    step();
    rst_i = 1'b1;
    chk_reset_state();
    mif.mem_rvalid = 1'b1; mif.mem_gnt = 1'b1; mif.mem_rdata = 32'hCAFE_BABE;
    step();
    mif.mem_rvalid = 1'b0; mif.mem_gnt = 1'b0;
    chk("late_valid", 32'(valid_o), 32'd0);
    chk("late_data", data_o, 32'd0);
    chk("late_req", 32'(mif.mem_req), 32'd0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t         tbl[16];
    instruction_t ri;
    logic [31:0]  rd_v, sd_v, d_v;
    int           kind;

    tbl[0]  = '{mki(7'b0110011, 3'd0, 5'd1), 32'h1234, 32'h0, 32'h0, 0, 0, 0,
                mke(0, 0, 4'h0, 32'h0, 0, 32'h1234)};
    tbl[1]  = '{mki(7'b0100011, 3'd0, 5'd0), 32'h103, 32'hA5, 32'h0, 0, 0, 0,
                mke(1, 1, 4'b1000, 32'hA5A5_A5A5, 0, 32'h103)};
    tbl[2]  = '{mki(7'b0000011, 3'd0, 5'd2), 32'h102, 32'h0, 32'h0080_0000, 0, 0, 0,
                mke(1, 0, 4'b0100, 32'h0, 0, 32'hFFFF_FF80)};
    tbl[3]  = '{mki(7'b0000011, 3'd4, 5'd3), 32'h102, 32'h0, 32'h0080_0000, 0, 0, 0,
                mke(1, 0, 4'b0100, 32'h0, 0, 32'h0000_0080)};
    tbl[4]  = '{mki(7'b0000011, 3'd1, 5'd4), 32'h102, 32'h0, 32'h8001_0000, 0, 0, 0,
                mke(1, 0, 4'b1100, 32'h0, 0, 32'hFFFF_8001)};
    tbl[5]  = '{mki(7'b0000011, 3'd2, 5'd5), 32'h101, 32'h0, 32'h0, 0, 0, 0,
                mke(0, 0, 4'h0, 32'h0, 1, 32'h101)};
    tbl[6]  = '{mki(7'b0000011, 3'd2, 5'd6), 32'h200, 32'h0, 32'hDEAD_BEEF, 3, 2, 2,
                mke(1, 0, 4'b1111, 32'h0, 0, 32'hDEAD_BEEF)};
    tbl[7]  = '{mki(7'b0100011, 3'd2, 5'd0), 32'h204, 32'h1122_3344, 32'h0, 3, 0, 2,
                mke(1, 1, 4'b1111, 32'h1122_3344, 0, 32'h204)};
    tbl[8]  = '{mki(7'b0100011, 3'd1, 5'd0), 32'h206, 32'hABCD_1234, 32'h0, 1, 0, 0,
                mke(1, 1, 4'b1100, 32'h1234_1234, 0, 32'h206)};
    tbl[9]  = '{mki(7'b0000011, 3'd5, 5'd8), 32'h106, 32'h0, 32'h89AB_0000, 0, 1, 0,
                mke(1, 0, 4'b1100, 32'h0, 0, 32'h0000_89AB)};
    tbl[10] = '{mki(7'b0000011, 3'd3, 5'd9), 32'h40, 32'h0, 32'h0, 0, 0, 0,
                mke(0, 0, 4'h0, 32'h0, 1, 32'h40)};
    tbl[11] = '{mki(7'b0100011, 3'd3, 5'd0), 32'h48, 32'h5, 32'h0, 0, 0, 0,
                mke(0, 0, 4'h0, 32'h0, 1, 32'h48)};
    tbl[12] = '{mki(7'b0100011, 3'd1, 5'd0), 32'h101, 32'h5, 32'h0, 0, 0, 1,
                mke(0, 0, 4'h0, 32'h0, 1, 32'h101)};
    tbl[13] = '{mki(7'b0000011, 3'd1, 5'd10), 32'h103, 32'h0, 32'h0, 0, 0, 0,
                mke(0, 0, 4'h0, 32'h0, 1, 32'h103)};
    tbl[14] = '{mki(7'b0100011, 3'd0, 5'd0), 32'h100, 32'h5A, 32'h0, 0, 0, 0,
                mke(1, 1, 4'b0001, 32'h5A5A_5A5A, 0, 32'h100)};
    tbl[15] = '{mki(7'b0000011, 3'd0, 5'd11), 32'h101, 32'h0, 32'h0000_7F00, 2, 3, 1,
                mke(1, 0, 4'b0010, 32'h0, 0, 32'h0000_007F)};

    rst_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    instruction_i = instruction_t'(32'h0); data_i = 32'h0; store_data_i = 32'h0;
    mif.mem_gnt = 1'b0; mif.mem_rvalid = 1'b0; mif.mem_rdata = 32'h0;
    step();
    step();
    cur_tag = "reset";
    chk_reset_state();
    rst_i = 1'b1;
    step();

    for (int i = 0; i < 16; i++)
      run_op($sformatf("vec%0d", i), tbl[i].ins, tbl[i].d, tbl[i].sd, tbl[i].rd,
             tbl[i].gd, tbl[i].rvd, tbl[i].rdyd, tbl[i].e);

    reset_mid("rst_wait", 1'b1);
    run_op("post_rst_wait", mki(7'b0110011, 3'd0, 5'd1), 32'h55, 32'h0, 32'h0, 0, 0, 0,
           mke(0, 0, 4'h0, 32'h0, 0, 32'h55));
    reset_mid("rst_req", 1'b0);
    run_op("post_rst_req", mki(7'b0010011, 3'd0, 5'd2), 32'hAA, 32'h0, 32'h0, 0, 0, 0,
           mke(0, 0, 4'h0, 32'h0, 0, 32'hAA));

    for (int i = 0; i < 200; i++) begin
      ri = instruction_t'($urandom);
      kind = $urandom_range(0, 4);
      ri.opcode = (kind < 2) ? 7'b0000011 : (kind < 4) ? 7'b0100011 : 7'b0110011;
      d_v = $urandom; sd_v = $urandom; rd_v = $urandom;
      run_op($sformatf("rnd%0d", i), ri, d_v, sd_v, rd_v,
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
             model(ri, d_v, sd_v, rd_v));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
